// File: rtl/branch_cmp_pkg.sv
// Shared types and sizing helpers for the sequential branch comparator.
package branch_cmp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        DONE = 2'd2
    } cmp_state_e;

    // Number of CHUNK-bit slices in a WIDTH-bit operand.
    function automatic int unsigned calc_nchunk(int unsigned width, int unsigned chunk);
        return (chunk == 0) ? 1 : width / chunk;
    endfunction

    // Chunk index width, never narrower than one bit.
    function automatic int unsigned calc_idx_w(int unsigned nchunk);
        return (nchunk <= 1) ? 1 : $clog2(nchunk);
    endfunction

endpackage

// File: rtl/seq_branch_comparator_chunk.sv
// Combinational unsigned compare of one CHUNK-bit slice.
module chunk_comparator #(
    parameter int unsigned CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    output logic             lt,
    output logic             eq
);

    assign lt = (a < b);
    assign eq = (a == b);

endmodule

// File: rtl/seq_branch_comparator.sv
// Multi-cycle signed/unsigned less-than / equality comparator, MSB chunk first.
// Build option CMP_EARLY_EXIT_EN: finish as soon as the result is known;
// otherwise always walk every chunk for a constant latency.
module seq_branch_comparator
    import branch_cmp_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CHUNK = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_rs1_data,
    input  logic [WIDTH-1:0] i_rs2_data,
    input  logic             i_br_un,
    output logic             o_valid,
    input  logic             i_ready,
    output logic             o_br_less,
    output logic             o_br_equal
);

    localparam int unsigned NCHUNK = calc_nchunk(WIDTH, CHUNK);
    localparam int unsigned IDX_W  = calc_idx_w(NCHUNK);

    if (CHUNK == 0 || CHUNK > WIDTH) begin : g_chk_chunk
        $error("CHUNK must be in 1..WIDTH");
    end
    if (CHUNK != 0 && (WIDTH % CHUNK) != 0) begin : g_chk_div
        $error("CHUNK must divide WIDTH exactly");
    end
    if (WIDTH < 2) begin : g_chk_width
        $error("WIDTH must be at least 2");
    end

    cmp_state_e       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             less_q, less_d;
    logic             equal_q, equal_d;
`ifndef CMP_EARLY_EXIT_EN
    // Result already fixed; remaining chunks are walked only for timing.
    logic             decided_q, decided_d;
`endif

    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;
    logic             chunk_lt;
    logic             chunk_eq;
    logic             sign_diff;

    assign a_chunk   = a_q[32'(idx_q) * CHUNK +: CHUNK];
    assign b_chunk   = b_q[32'(idx_q) * CHUNK +: CHUNK];
    assign sign_diff = !i_br_un && (i_rs1_data[WIDTH-1] != i_rs2_data[WIDTH-1]);

    chunk_comparator #(
        .CHUNK (CHUNK)
    ) u_chunk_cmp (
        .a  (a_chunk),
        .b  (b_chunk),
        .lt (chunk_lt),
        .eq (chunk_eq)
    );

    // Next-state and datapath update for the chunk walk.
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        idx_d     = idx_q;
        less_d    = less_q;
        equal_d   = equal_q;
`ifndef CMP_EARLY_EXIT_EN
        decided_d = decided_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (i_valid) begin
                    a_d     = i_rs1_data;
                    b_d     = i_rs2_data;
                    idx_d   = IDX_W'(NCHUNK - 1);
                    less_d  = 1'b0;
                    equal_d = 1'b0;
`ifdef CMP_EARLY_EXIT_EN
                    if (sign_diff) begin
                        // Differing signs: the negative operand is the smaller one.
                        less_d  = i_rs1_data[WIDTH-1];
                        state_d = DONE;
                    end else begin
                        state_d = CMP;
                    end
`else
                    decided_d = sign_diff;
                    if (sign_diff) begin
                        less_d = i_rs1_data[WIDTH-1];
                    end
                    state_d = CMP;
`endif
                end
            end
            CMP: begin
`ifdef CMP_EARLY_EXIT_EN
                if (chunk_lt) begin
                    less_d  = 1'b1;
                    state_d = DONE;
                end else if (!chunk_eq) begin
                    state_d = DONE;
                end else if (idx_q == '0) begin
                    equal_d = 1'b1;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q - 1'b1;
                end
`else
                if (!decided_q && !chunk_eq) begin
                    less_d    = chunk_lt;
                    decided_d = 1'b1;
                end
                if (idx_q == '0) begin
                    if (!decided_q && chunk_eq) begin
                        equal_d = 1'b1;
                    end
                    state_d = DONE;
                end else begin
                    idx_d = idx_q - 1'b1;
                end
`endif
            end
            DONE: begin
                if (i_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            idx_q     <= '0;
            less_q    <= 1'b0;
            equal_q   <= 1'b0;
`ifndef CMP_EARLY_EXIT_EN
            decided_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            idx_q     <= idx_d;
            less_q    <= less_d;
            equal_q   <= equal_d;
`ifndef CMP_EARLY_EXIT_EN
            decided_q <= decided_d;
`endif
        end
    end

    assign o_ready    = (state_q == IDLE);
    assign o_valid    = (state_q == DONE);
    assign o_br_less  = less_q;
    assign o_br_equal = equal_q;

endmodule

// File: tb/tb_seq_branch_comparator.sv
// Randomized self-checking bench for seq_branch_comparator against a reference model.
module tb_seq_branch_comparator;

    localparam int unsigned WIDTH  = 32;
    localparam int unsigned CHUNK  = 8;
    localparam int unsigned NCHUNK = WIDTH / CHUNK;
    localparam int          BUDGET = 20;

    logic             i_clk = 1'b0;
    logic             i_rst;
    logic             i_valid;
    logic             o_ready;
    logic [WIDTH-1:0] i_rs1_data;
    logic [WIDTH-1:0] i_rs2_data;
    logic             i_br_un;
    logic             o_valid;
    logic             i_ready;
    logic             o_br_less;
    logic             o_br_equal;

    int checks   = 0;
    int failures = 0;

    seq_branch_comparator #(
        .WIDTH (WIDTH),
        .CHUNK (CHUNK)
    ) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .i_rs1_data (i_rs1_data),
        .i_rs2_data (i_rs2_data),
        .i_br_un    (i_br_un),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_br_less  (o_br_less),
        .o_br_equal (o_br_equal)
    );

    always #5 i_clk = ~i_clk;

    task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: result from integer comparison, latency from the chunk rules.
    function automatic int model_latency(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                         input logic un);
`ifdef CMP_EARLY_EXIT_EN
        logic [WIDTH-1:0] x;
        if (!un && (a[WIDTH-1] != b[WIDTH-1])) return 1;
        x = a ^ b;
        for (int k = 1; k <= int'(NCHUNK); k++) begin
            if (x[(int'(NCHUNK) - k) * int'(CHUNK) +: CHUNK] != '0) return 1 + k;
        end
        return 1 + int'(NCHUNK);
`else
        if (a == b && un) return 1 + int'(NCHUNK);
        return 1 + int'(NCHUNK);
`endif
    endfunction

    // Issue one request, measure latency, stall, then drain. Starts/ends at a negedge in IDLE.
    task automatic run_req(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic un,
                           input int stall);
        logic exp_less;
        logic exp_eq;
        int   exp_lat;
        int   lat;
        exp_less = un ? (a < b) : ($signed(a) < $signed(b));
        exp_eq   = (a == b);
        exp_lat  = model_latency(a, b, un);
        check_value("ready_idle", 64'(o_ready), 64'd1);
        i_rs1_data = a;
        i_rs2_data = b;
        i_br_un    = un;
        i_valid    = 1'b1;
        i_ready    = 1'b0;
        @(posedge i_clk);
        @(negedge i_clk);
        i_valid    = 1'b0;
        i_rs1_data = $urandom;
        i_rs2_data = $urandom;
        i_br_un    = 1'($urandom);
        lat = 1;
        while (!o_valid && lat < BUDGET) begin
            check_value("ready_busy", 64'(o_ready), 64'd0);
            @(negedge i_clk);
            lat++;
        end
        check_value("latency", 64'(lat), 64'(exp_lat));
        check_value("less", 64'(o_br_less), 64'(exp_less));
        check_value("equal", 64'(o_br_equal), 64'(exp_eq));
        for (int s = 0; s < stall; s++) begin
            i_valid    = 1'b1;
            i_rs1_data = $urandom;
            i_rs2_data = $urandom;
            @(negedge i_clk);
            check_value("stall_valid", 64'(o_valid), 64'd1);
            check_value("stall_ready", 64'(o_ready), 64'd0);
            check_value("stall_less", 64'(o_br_less), 64'(exp_less));
            check_value("stall_equal", 64'(o_br_equal), 64'(exp_eq));
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        @(negedge i_clk);
        i_ready = 1'b0;
        check_value("drain_valid", 64'(o_valid), 64'd0);
        check_value("drain_ready", 64'(o_ready), 64'd1);
    endtask

    initial begin
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        int               mode;
        int               bit_pos;
        i_rst      = 1'b1;
        i_valid    = 1'b0;
        i_ready    = 1'b0;
        i_rs1_data = '0;
        i_rs2_data = '0;
        i_br_un    = 1'b0;
        repeat (2) @(negedge i_clk);
        check_value("rst_ready", 64'(o_ready), 64'd1);
        check_value("rst_valid", 64'(o_valid), 64'd0);
        check_value("rst_less", 64'(o_br_less), 64'd0);
        check_value("rst_equal", 64'(o_br_equal), 64'd0);
        i_rst = 1'b0;
        @(negedge i_clk);

        run_req(32'h0000_0001, 32'h0000_0002, 1'b1, 0);
        run_req(32'h8000_0000, 32'h0000_0001, 1'b0, 0);
        run_req(32'h8000_0000, 32'h0000_0001, 1'b1, 1);
        run_req(32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 0);
        run_req(32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1, 0);
        run_req(32'hFFFF_FFFE, 32'hFFFF_FFFF, 1'b0, 0);
        run_req(32'h7FFF_FFFF, 32'h8000_0000, 1'b0, 2);
        run_req(32'h0000_0000, 32'hFFFF_FFFF, 1'b1, 3);

        // Reset in the middle of a walk discards the request.
        i_rs1_data = 32'h1234_0000;
        i_rs2_data = 32'h1234_FFFF;
        i_br_un    = 1'b1;
        i_valid    = 1'b1;
        @(posedge i_clk);
        @(negedge i_clk);
        i_valid = 1'b0;
        @(negedge i_clk);
        i_rst = 1'b1;
        @(negedge i_clk);
        i_rst = 1'b0;
        check_value("midrst_valid", 64'(o_valid), 64'd0);
        check_value("midrst_ready", 64'(o_ready), 64'd1);
        check_value("midrst_less", 64'(o_br_less), 64'd0);
        check_value("midrst_equal", 64'(o_br_equal), 64'd0);
        run_req(32'h1234_0000, 32'h1234_FFFF, 1'b1, 0);

        for (int n = 0; n < 200; n++) begin
            a    = $urandom;
            b    = a;
            mode = int'($urandom_range(0, 3));
            if (mode == 0) begin
                b = $urandom;
            end else if (mode == 2) begin
                bit_pos    = int'($urandom_range(0, WIDTH - 1));
                b[bit_pos] = ~b[bit_pos];
            end else if (mode == 3) begin
                bit_pos    = int'($urandom_range(0, WIDTH - 1));
                b[bit_pos] = ~b[bit_pos];
                b[0]       = ~b[0];
            end
            run_req(a, b, 1'($urandom), int'($urandom_range(0, 2)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
